mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port op, input, 7, opcode field from the instruction register; stable from the cycle after FETCH.
REQ-004 SHALL have port funct3, input, 3, instruction bits 14:12.
REQ-005 SHALL have port funct7b5, input, 1, instruction bit 30.
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port pcwrite, output, 1, PC register enable; equals pcupdate OR (branch AND zero).
REQ-008 SHALL have port adrsrc, output, 1, memory address select: 0 = PC, 1 = ALU result register.
REQ-009 SHALL have port memwrite, output, 1, data memory write strobe.
REQ-010 SHALL have port irwrite, output, 1, instruction register and old-PC enable.
REQ-011 SHALL have port resultsrc, output, 2, result select: 00 = ALU out register, 01 = read data, 10 = ALU result.
REQ-012 SHALL have port alusrca, output, 2, ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-013 SHALL have port alusrcb, output, 2, ALU B select: 00 = rs2, 01 = immext, 10 = constant 4.
REQ-014 SHALL have port immsrc, output, 2, immediate format select driving the extender.
REQ-015 SHALL have port alucontrol, output, 3, ALU operation select.
REQ-016 SHALL have port regwrite, output, 1, register file write enable.
REQ-017 SHALL have port instr_done, output, 1, one-cycle pulse in the final state of each instruction.
REQ-018 SHALL have port illegal, output, 1, one-cycle pulse in DECODE when op is unsupported.

Function
REQ-019 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-020 SHALL transition FETCH->DECODE unconditionally.
REQ-021 SHALL transition out of DECODE on op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> FETCH with illegal=1 and instr_done=1.
REQ-022 SHALL transition MEMADR->MEMREAD for op=0000011, else ->MEMWRITE; MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL -> ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
REQ-023 SHALL drive the following Moore outputs per state; unlisted outputs are 0:
  - FETCH: irwrite=1, alusrcb=10, resultsrc=10, pcupdate=1.
  - DECODE: alusrca=01, alusrcb=01.
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: regwrite=1.
  - BEQ: alusrca=10, aluop=01, branch=1.
  - JAL: alusrca=01, alusrcb=10, pcupdate=1.
REQ-024 SHALL assert instr_done in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE for an illegal op.
REQ-025 SHALL produce the following latencies in cycles, FETCH to the last state inclusive: lw 5; sw, R-type, I-ALU and jal 4; beq 3; illegal 2.
REQ-026 SHALL decode immsrc combinationally from op: 0000011 and 0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other value -> 00.
REQ-027 SHALL decode alucontrol combinationally:
  - aluop 00 -> 000 (add); aluop 01 -> 001 (sub).
  - aluop 10 with funct3 000 -> 001 when op[5] and funct7b5 are both 1, else 000.
  - aluop 10 with funct3 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - aluop 11 -> 000.
REQ-028 SHALL derive pcwrite combinationally in the same cycle from zero in BEQ, with no added latency.
REQ-029 SHALL return to FETCH from any unused or corrupted state encoding on the next edge.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, force the state to FETCH, overriding any state, including an instruction in progress.
REQ-031 SHALL drive, during and after reset, exactly the FETCH output values; instr_done=0 and illegal=0.

Structure
REQ-032 SHALL place the state enum, aluop encoding, opcode constants and immsrc and alucontrol encodings in a shared package, riscv_pkg.
REQ-033 SHALL contain the combinational sub-module alu_decoder (aluop, funct3, op[5], funct7b5 -> alucontrol); immsrc decoding and the FSM remain inline.

Verification
REQ-034 SHALL cover: reset, then op=0000011 held -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 and resultsrc=01 only in cycle 5; instr_done pulses once in cycle 5.
REQ-035 SHALL cover: op=0100011 -> memwrite=1 and adrsrc=1 in cycle 4 only; immsrc=01 throughout; regwrite never asserted.
REQ-036 SHALL cover: op=1100011, funct3=000 with zero=1 in the BEQ cycle -> pcwrite=1, alucontrol=001, immsrc=10; repeat with zero=0 -> pcwrite=0; next state FETCH in both cases.
REQ-037 SHALL cover: op=0110011, funct3=000, funct7b5=1 -> alucontrol=001 in EXECUTER; with op=0010011 and the same funct fields -> alucontrol=000.
REQ-038 SHALL cover: op=1111111 -> illegal=1 and instr_done=1 in DECODE, FETCH on the next cycle.
REQ-039 SHALL cover: rst_n=0 asserted during MEMREAD -> FETCH outputs (irwrite=1, pcupdate path pcwrite=1) on the next cycle.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, FSM states,
// ALU op classes, immediate formats and ALU operation codes.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Explicit 4-bit encodings keep the state register layout stable across
    // tool flows; codes 11..15 are unused and recover to FETCH.
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;

    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;
    localparam aluop_t ALUOP_RSVD  = 2'b11;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: return 1'b1;
            default:                                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, alucontrol, regwrite, instr_done, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               immsrc, alucontrol, regwrite, instr_done, illegal
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// Maps the FSM's ALU op class plus instruction funct fields to an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type; addi with bit 30 set is still add
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            ALUOP_RSVD: alucontrol = ALU_ADD;
            default:    alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM with inline immediate decode
// and an ALU decoder sub-block.
module mc_controller
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mc_controller_if.master     ctrl
);

    state_t     state_q, state_d;
    aluop_t     aluop;
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        pcupdate   = 1'b0;
        branch     = 1'b0;
        adrsrc     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_ADD;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALURES;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_IMM;
                illegal    = !op_supported(ctrl.op);
                instr_done = !op_supported(ctrl.op);
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
            end
            S_MEMREAD: adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc  = RES_RDATA;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alusrca    = SRCA_RS1;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alusrca  = SRCA_OLDPC;
                alusrcb  = SRCB_FOUR;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        immsrc = IMM_I;
        case (ctrl.op)
            OP_LOAD, OP_ITYPE: immsrc = IMM_I;
            OP_STORE:          immsrc = IMM_S;
            OP_BRANCH:         immsrc = IMM_B;
            OP_JAL:            immsrc = IMM_J;
            default:           immsrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (ctrl.funct3),
        .op5        (ctrl.op[5]),
        .funct7b5   (ctrl.funct7b5),
        .alucontrol (alucontrol)
    );

    assign ctrl.pcwrite    = pcupdate | (branch & ctrl.zero);
    assign ctrl.adrsrc     = adrsrc;
    assign ctrl.memwrite   = memwrite;
    assign ctrl.irwrite    = irwrite;
    assign ctrl.resultsrc  = resultsrc;
    assign ctrl.alusrca    = alusrca;
    assign ctrl.alusrcb    = alusrcb;
    assign ctrl.immsrc     = immsrc;
    assign ctrl.alucontrol = alucontrol;
    assign ctrl.regwrite   = regwrite;
    assign ctrl.instr_done = instr_done;
    assign ctrl.illegal    = illegal;

endmodule
